// File: rtl/laser_score_if.sv
// laser_score_if: groups the point stream, placer result and score outputs
// of the laser_score stage.
//   slave  modport : used by laser_score (consumes stream/centres, drives score)
//   master modport : used by the placer-side driver
// Optional macro LASER_SCORE_BEST_EN adds BEST_COVER / BEST_C1 / BEST_C2.
interface laser_score_if;
  logic       PT_VALID;
  logic [3:0] X;
  logic [3:0] Y;
  logic       DONE;
  logic [3:0] C1X;
  logic [3:0] C1Y;
  logic [3:0] C2X;
  logic [3:0] C2Y;
  logic       BUSY;
  logic       SCORE_VALID;
  logic [5:0] COVER;
  logic [5:0] COV1;
  logic [5:0] COV2;
  logic       PT_DROP;
`ifdef LASER_SCORE_BEST_EN
  logic [5:0] BEST_COVER;
  logic [7:0] BEST_C1;
  logic [7:0] BEST_C2;

  modport slave (
    input  PT_VALID, X, Y, DONE, C1X, C1Y, C2X, C2Y,
    output BUSY, SCORE_VALID, COVER, COV1, COV2, PT_DROP,
    output BEST_COVER, BEST_C1, BEST_C2
  );
  modport master (
    output PT_VALID, X, Y, DONE, C1X, C1Y, C2X, C2Y,
    input  BUSY, SCORE_VALID, COVER, COV1, COV2, PT_DROP,
    input  BEST_COVER, BEST_C1, BEST_C2
  );
`else
  modport slave (
    input  PT_VALID, X, Y, DONE, C1X, C1Y, C2X, C2Y,
    output BUSY, SCORE_VALID, COVER, COV1, COV2, PT_DROP
  );
  modport master (
    output PT_VALID, X, Y, DONE, C1X, C1Y, C2X, C2Y,
    input  BUSY, SCORE_VALID, COVER, COV1, COV2, PT_DROP
  );
`endif
endinterface

// File: rtl/laser_score.sv
// laser_score: snoops the placer's point stream into a buffer, latches the two
// circle centres on DONE, then walks the buffer one point per cycle counting
// points within radius sqrt(R2) of C1, of C2 and of either.
// Ports:
//   CLK  - clock, all state on rising edge
//   RST  - synchronous active-high reset
//   bus  - laser_score_if.slave: PT_VALID/X/Y stream, DONE + C1X..C2Y,
//          BUSY, SCORE_VALID, COVER/COV1/COV2, PT_DROP
// Optional macro LASER_SCORE_BEST_EN adds the best-of-runs tracker outputs
// BEST_COVER, BEST_C1 {x,y}, BEST_C2 {x,y}.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for first point of a frame
// LOAD      | storing points until NPTS have been accepted
// WAIT_DONE | frame complete, waiting for the placer DONE strobe
// EVAL      | walking the buffer, one point per cycle, plus one drain cycle
// REPORT    | SCORE_VALID high for one cycle
module laser_score #(
  parameter int NPTS = 40,
  parameter int R2   = 16
) (
  input logic         CLK,
  input logic         RST,
  laser_score_if.slave bus
);
  localparam int CW = $clog2(NPTS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DONE, EVAL, REPORT} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   idx_q;
  logic [3:0]      px_q [NPTS];
  logic [3:0]      py_q [NPTS];
  logic [3:0]      c1x_q, c1y_q, c2x_q, c2y_q;
  logic            hit1_q, hit2_q, hitv_q;
  logic            busy_q, score_valid_q, pt_drop_q;
  logic [5:0]      cover_q, cov1_q, cov2_q;
`ifdef LASER_SCORE_BEST_EN
  logic [5:0]      best_cover_q;
  logic [7:0]      best_c1_q, best_c2_q;
`endif

  logic            accepting_d;
  logic            store_d;
  logic [CW-1:0]   store_idx_d;
  logic [CW-1:0]   rd_idx_d;
  logic            walking_d;
  logic            hit1_d, hit2_d;

  function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic inside_r(input logic [3:0] px, input logic [3:0] py,
                                    input logic [3:0] cx, input logic [3:0] cy);
    logic [7:0] dx, dy;
    logic [8:0] sum;
    dx  = {4'b0, abs_diff(px, cx)};
    dy  = {4'b0, abs_diff(py, cy)};
    sum = {1'b0, dx * dx} + {1'b0, dy * dy};
    return sum <= 9'(R2);
  endfunction

  always_comb begin
    accepting_d = (state_q == IDLE) || (state_q == LOAD);
    store_d     = bus.PT_VALID && accepting_d;
    store_idx_d = (state_q == IDLE) ? '0 : cnt_q;
    walking_d   = (idx_q < CW'(NPTS));
    // Clamp so the drain cycle (idx_q == NPTS) never reads past the buffer.
    rd_idx_d    = walking_d ? idx_q : '0;
    hit1_d      = inside_r(px_q[rd_idx_d], py_q[rd_idx_d], c1x_q, c1y_q);
    hit2_d      = inside_r(px_q[rd_idx_d], py_q[rd_idx_d], c2x_q, c2y_q);
  end

  // Buffer is never cleared: every entry is written before the walk reads it.
  always_ff @(posedge CLK) begin
    if (store_d) begin
      px_q[store_idx_d] <= bus.X;
      py_q[store_idx_d] <= bus.Y;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      c1x_q         <= '0;
      c1y_q         <= '0;
      c2x_q         <= '0;
      c2y_q         <= '0;
      hit1_q        <= 1'b0;
      hit2_q        <= 1'b0;
      hitv_q        <= 1'b0;
      busy_q        <= 1'b0;
      score_valid_q <= 1'b0;
      pt_drop_q     <= 1'b0;
      cover_q       <= '0;
      cov1_q        <= '0;
      cov2_q        <= '0;
`ifdef LASER_SCORE_BEST_EN
      best_cover_q  <= '0;
      best_c1_q     <= '0;
      best_c2_q     <= '0;
`endif
    end else begin
      score_valid_q <= 1'b0;
      if (bus.PT_VALID && !accepting_d) pt_drop_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.PT_VALID) begin
            cnt_q  <= CW'(1);
            busy_q <= 1'b1;
            state_q <= (NPTS == 1) ? WAIT_DONE : LOAD;
          end
        end
        LOAD: begin
          if (bus.PT_VALID) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(NPTS - 1)) state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (bus.DONE) begin
            c1x_q   <= bus.C1X;
            c1y_q   <= bus.C1Y;
            c2x_q   <= bus.C2X;
            c2y_q   <= bus.C2Y;
            cover_q <= '0;
            cov1_q  <= '0;
            cov2_q  <= '0;
            idx_q   <= '0;
            hitv_q  <= 1'b0;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          // Hit flags are registered, so accumulation trails the walk by one
          // cycle; the extra drain cycle folds in the last point.
          if (hitv_q) begin
            cov1_q  <= cov1_q  + {5'b0, hit1_q};
            cov2_q  <= cov2_q  + {5'b0, hit2_q};
            cover_q <= cover_q + {5'b0, hit1_q | hit2_q};
          end
          if (walking_d) begin
            hit1_q <= hit1_d;
            hit2_q <= hit2_d;
            hitv_q <= 1'b1;
            idx_q  <= idx_q + CW'(1);
          end else begin
            hitv_q        <= 1'b0;
            score_valid_q <= 1'b1;
            state_q       <= REPORT;
          end
        end
        REPORT: begin
`ifdef LASER_SCORE_BEST_EN
          if (cover_q > best_cover_q) begin
            best_cover_q <= cover_q;
            best_c1_q    <= {c1x_q, c1y_q};
            best_c2_q    <= {c2x_q, c2y_q};
          end
`endif
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY        = busy_q;
  assign bus.SCORE_VALID = score_valid_q;
  assign bus.COVER       = cover_q;
  assign bus.COV1        = cov1_q;
  assign bus.COV2        = cov2_q;
  assign bus.PT_DROP     = pt_drop_q;
`ifdef LASER_SCORE_BEST_EN
  assign bus.BEST_COVER  = best_cover_q;
  assign bus.BEST_C1     = best_c1_q;
  assign bus.BEST_C2     = best_c2_q;
`endif

endmodule

// File: tb/tb_laser_score.sv
// tb_laser_score: directed self-checking bench for laser_score.
// Optional macro LASER_SCORE_BEST_EN enables the best-of-runs scenario.
module tb_laser_score;
  logic CLK;
  logic RST;
  int   errors;
  int   checks;
  logic [3:0] px [40];
  logic [3:0] py [40];

  laser_score_if bus ();

  laser_score #(.NPTS(40), .R2(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic load_frame;
    for (int i = 0; i < 40; i++) begin
      bus.PT_VALID = 1'b1;
      bus.X = px[i];
      bus.Y = py[i];
      tick();
    end
    bus.PT_VALID = 1'b0;
  endtask

  task automatic send_done(input logic [3:0] c1x, input logic [3:0] c1y,
                           input logic [3:0] c2x, input logic [3:0] c2y);
    bus.C1X = c1x; bus.C1Y = c1y; bus.C2X = c2x; bus.C2Y = c2y;
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
  endtask

  task automatic wait_score(output int lat);
    lat = 0;
    while (bus.SCORE_VALID !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    bus.PT_VALID = 1'b0; bus.X = '0; bus.Y = '0;
    bus.C1X = '0; bus.C1Y = '0; bus.C2X = '0; bus.C2Y = '0;
    bus.DONE = 1'b1;
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    checks++; if (bus.SCORE_VALID !== 1'b0) begin errors++; $display("FAIL reset_sv: got %b want 0", bus.SCORE_VALID); end
    checks++; if (bus.COVER !== 6'd0) begin errors++; $display("FAIL reset_cover: got %0d want 0", bus.COVER); end
    checks++; if (bus.COV1 !== 6'd0 || bus.COV2 !== 6'd0) begin errors++; $display("FAIL reset_cov12: got %0d/%0d want 0/0", bus.COV1, bus.COV2); end
    checks++; if (bus.PT_DROP !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", bus.PT_DROP); end
    // Placer holds DONE high after reset; IDLE must ignore it.
    repeat (3) tick();
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_done_level_busy: got %b want 0", bus.BUSY); end
    bus.DONE = 1'b0;
    tick();
  endtask

  task automatic test_all_zero;
    int lat;
    for (int i = 0; i < 40; i++) begin px[i] = 4'd0; py[i] = 4'd0; end
    load_frame();
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL zero_busy_wait: got %b want 1", bus.BUSY); end
    send_done(4'd0, 4'd0, 4'd15, 4'd15);
    wait_score(lat);
    checks++; if (lat != 41) begin errors++; $display("FAIL zero_latency: got %0d want 41", lat); end
    checks++; if (bus.COVER !== 6'd40) begin errors++; $display("FAIL zero_cover: got %0d want 40", bus.COVER); end
    checks++; if (bus.COV1 !== 6'd40) begin errors++; $display("FAIL zero_cov1: got %0d want 40", bus.COV1); end
    checks++; if (bus.COV2 !== 6'd0) begin errors++; $display("FAIL zero_cov2: got %0d want 0", bus.COV2); end
    tick();
    checks++; if (bus.SCORE_VALID !== 1'b0) begin errors++; $display("FAIL zero_sv_pulse: got %b want 0", bus.SCORE_VALID); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL zero_busy_idle: got %b want 0", bus.BUSY); end
    checks++; if (bus.COVER !== 6'd40) begin errors++; $display("FAIL zero_cover_hold: got %0d want 40", bus.COVER); end
  endtask

  task automatic set_boundary;
    for (int i = 0; i < 40; i++) begin px[i] = 4'd15; py[i] = 4'd0; end
    px[0] = 4'd4; py[0] = 4'd0;
    px[1] = 4'd0; py[1] = 4'd4;
    px[2] = 4'd3; py[2] = 4'd3;
    px[3] = 4'd2; py[3] = 4'd3;
  endtask

  task automatic test_boundary;
    int lat;
    set_boundary();
    load_frame();
    send_done(4'd0, 4'd0, 4'd8, 4'd8);
    wait_score(lat);
    checks++; if (lat != 41) begin errors++; $display("FAIL bound_latency: got %0d want 41", lat); end
    checks++; if (bus.COV1 !== 6'd3) begin errors++; $display("FAIL bound_cov1: got %0d want 3", bus.COV1); end
    checks++; if (bus.COV2 !== 6'd0) begin errors++; $display("FAIL bound_cov2: got %0d want 0", bus.COV2); end
    checks++; if (bus.COVER !== 6'd3) begin errors++; $display("FAIL bound_cover: got %0d want 3", bus.COVER); end
    tick();
  endtask

  task automatic test_overlap;
    int lat;
    for (int i = 0; i < 40; i++) begin px[i] = 4'd5; py[i] = 4'd5; end
    load_frame();
    send_done(4'd3, 4'd5, 4'd7, 4'd5);
    wait_score(lat);
    checks++; if (bus.COV1 !== 6'd40) begin errors++; $display("FAIL ovl_cov1: got %0d want 40", bus.COV1); end
    checks++; if (bus.COV2 !== 6'd40) begin errors++; $display("FAIL ovl_cov2: got %0d want 40", bus.COV2); end
    checks++; if (bus.COVER !== 6'd40) begin errors++; $display("FAIL ovl_cover: got %0d want 40", bus.COVER); end
    tick();
  endtask

  task automatic test_gapped_done;
    int   lat;
    logic sv_seen;
    // x = i mod 16, y = 0: C1=(0,0) hits x<=4 (15 pts), C2=(15,0) hits x>=11 (10 pts).
    for (int i = 0; i < 40; i++) begin px[i] = 4'(i % 16); py[i] = 4'd0; end
    for (int i = 0; i < 39; i++) begin
      bus.PT_VALID = 1'b1; bus.X = px[i]; bus.Y = py[i];
      tick();
      bus.PT_VALID = 1'b0;
      tick();
    end
    bus.C1X = 4'd0; bus.C1Y = 4'd0; bus.C2X = 4'd15; bus.C2Y = 4'd0;
    bus.DONE = 1'b1;
    tick();
    // Last point arrives together with DONE; both DONEs fall outside WAIT_DONE.
    bus.PT_VALID = 1'b1; bus.X = px[39]; bus.Y = py[39];
    tick();
    bus.PT_VALID = 1'b0; bus.DONE = 1'b0;
    sv_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.SCORE_VALID === 1'b1) sv_seen = 1'b1;
      tick();
    end
    checks++; if (sv_seen !== 1'b0) begin errors++; $display("FAIL gap_early_done: got sv=%b want 0", sv_seen); end
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL gap_wait_busy: got %b want 1", bus.BUSY); end
    checks++; if (bus.PT_DROP !== 1'b0) begin errors++; $display("FAIL gap_drop: got %b want 0", bus.PT_DROP); end
    send_done(4'd0, 4'd0, 4'd15, 4'd0);
    wait_score(lat);
    checks++; if (lat != 41) begin errors++; $display("FAIL gap_latency: got %0d want 41", lat); end
    checks++; if (bus.COV1 !== 6'd15) begin errors++; $display("FAIL gap_cov1: got %0d want 15", bus.COV1); end
    checks++; if (bus.COV2 !== 6'd10) begin errors++; $display("FAIL gap_cov2: got %0d want 10", bus.COV2); end
    checks++; if (bus.COVER !== 6'd25) begin errors++; $display("FAIL gap_cover: got %0d want 25", bus.COVER); end
    tick();
  endtask

  task automatic test_back_to_back;
    int lat;
    for (int i = 0; i < 40; i++) begin px[i] = 4'd0; py[i] = 4'd0; end
    load_frame();
    send_done(4'd0, 4'd0, 4'd15, 4'd15);
    wait_score(lat);
    checks++; if (bus.PT_DROP !== 1'b0) begin errors++; $display("FAIL b2b_drop_before: got %b want 0", bus.PT_DROP); end
    // Point (1,1) in the REPORT cycle must be dropped; if stored it would add a C1 hit.
    bus.PT_VALID = 1'b1; bus.X = 4'd1; bus.Y = 4'd1;
    tick();
    bus.PT_VALID = 1'b0;
    checks++; if (bus.PT_DROP !== 1'b1) begin errors++; $display("FAIL b2b_drop_report: got %b want 1", bus.PT_DROP); end
    set_boundary();
    load_frame();
    send_done(4'd0, 4'd0, 4'd8, 4'd8);
    wait_score(lat);
    checks++; if (lat != 41) begin errors++; $display("FAIL b2b_latency: got %0d want 41", lat); end
    checks++; if (bus.COV1 !== 6'd3) begin errors++; $display("FAIL b2b_cov1: got %0d want 3", bus.COV1); end
    checks++; if (bus.COVER !== 6'd3) begin errors++; $display("FAIL b2b_cover: got %0d want 3", bus.COVER); end
    tick();
  endtask

  task automatic test_rst_mid_eval;
    int lat;
    for (int i = 0; i < 40; i++) begin px[i] = 4'd5; py[i] = 4'd5; end
    load_frame();
    send_done(4'd3, 4'd5, 4'd7, 4'd5);
    repeat (20) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.BUSY); end
    checks++; if (bus.COVER !== 6'd0 || bus.COV1 !== 6'd0 || bus.COV2 !== 6'd0) begin
      errors++; $display("FAIL rst_counts: got %0d/%0d/%0d want 0/0/0", bus.COVER, bus.COV1, bus.COV2);
    end
    checks++; if (bus.PT_DROP !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b want 0", bus.PT_DROP); end
    tick();
    checks++; if (bus.BUSY !== 1'b0 || bus.SCORE_VALID !== 1'b0) begin
      errors++; $display("FAIL rst_idle: got busy=%b sv=%b want 0/0", bus.BUSY, bus.SCORE_VALID);
    end
    for (int i = 0; i < 40; i++) begin px[i] = 4'd0; py[i] = 4'd0; end
    load_frame();
    send_done(4'd15, 4'd15, 4'd0, 4'd0);
    repeat (3) tick();
    bus.PT_VALID = 1'b1; bus.X = 4'd15; bus.Y = 4'd15;
    tick();
    bus.PT_VALID = 1'b0;
    checks++; if (bus.PT_DROP !== 1'b1) begin errors++; $display("FAIL eval_drop: got %b want 1", bus.PT_DROP); end
    wait_score(lat);
    checks++; if (lat != 37) begin errors++; $display("FAIL fresh_latency: got %0d want 37", lat); end
    checks++; if (bus.COV1 !== 6'd0) begin errors++; $display("FAIL fresh_cov1: got %0d want 0", bus.COV1); end
    checks++; if (bus.COV2 !== 6'd40) begin errors++; $display("FAIL fresh_cov2: got %0d want 40", bus.COV2); end
    checks++; if (bus.COVER !== 6'd40) begin errors++; $display("FAIL fresh_cover: got %0d want 40", bus.COVER); end
    repeat (3) tick();
    checks++; if (bus.PT_DROP !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b want 1", bus.PT_DROP); end
  endtask

`ifdef LASER_SCORE_BEST_EN
  task automatic run_best_frame(input int n, input logic [3:0] c1, input logic [3:0] c2);
    int lat;
    for (int i = 0; i < 40; i++) begin
      px[i] = (i < n) ? 4'd0 : 4'd15;
      py[i] = (i < n) ? 4'd0 : 4'd15;
    end
    load_frame();
    send_done(c1, c1, c2, c2);
    wait_score(lat);
    checks++; if (bus.COVER !== 6'(n)) begin errors++; $display("FAIL best_frame_cover: got %0d want %0d", bus.COVER, n); end
    tick();
  endtask

  task automatic test_best;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (bus.BEST_COVER !== 6'd0) begin errors++; $display("FAIL best_reset: got %0d want 0", bus.BEST_COVER); end
    run_best_frame(30, 4'd0, 4'd8);
    checks++; if (bus.BEST_COVER !== 6'd30 || bus.BEST_C1 !== 8'h00 || bus.BEST_C2 !== 8'h88) begin
      errors++; $display("FAIL best_first: got %0d/%h/%h want 30/00/88", bus.BEST_COVER, bus.BEST_C1, bus.BEST_C2);
    end
    run_best_frame(35, 4'd1, 4'd9);
    run_best_frame(35, 4'd2, 4'd10);
    checks++; if (bus.BEST_COVER !== 6'd35) begin errors++; $display("FAIL best_cover: got %0d want 35", bus.BEST_COVER); end
    checks++; if (bus.BEST_C1 !== 8'h11) begin errors++; $display("FAIL best_c1: got %h want 11", bus.BEST_C1); end
    checks++; if (bus.BEST_C2 !== 8'h99) begin errors++; $display("FAIL best_c2: got %h want 99", bus.BEST_C2); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    RST = 1'b1;
    bus.PT_VALID = 1'b0;
    bus.DONE = 1'b0;
    test_reset();
    test_all_zero();
    test_boundary();
    test_overlap();
    test_gapped_done();
    test_back_to_back();
    test_rst_mid_eval();
`ifdef LASER_SCORE_BEST_EN
    test_best();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
